rp_stream_ctrl: RTL

RP_STREAM_CTRL -- requirements
Module: rp_stream_ctrl

---
 rtl/rp_stream_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rp_stream_ctrl.sv
`timescale 1ns/1ps
// rp_stream_ctrl: streams operand pairs into a reconfigurable partition (RP),
// tracks each accepted pair with a tag shift register, and collects the
// registered RP results into an output FIFO in accept order. Credits against
// the FIFO guarantee that every in-flight result has a slot. While the
// partition is decoupled, in-flight results are discarded and counted.
//
// Ports:
//   Clk, Reset_n          clock, synchronous active-low reset
//   s_valid/s_ready       operand pair handshake; s_a, s_b operands
//   ain, bin              registered operands driven to the partition
//   rp_result             registered result returned by the partition
//   decouple              partition under reconfiguration
//   m_valid/m_ready       result handshake; m_data = FIFO head
//   inflight              accepted pairs whose result is not yet in the FIFO
//   drop_cnt              saturating count of results discarded by decouple
module rp_stream_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RP_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_a,
  input  logic [31:0] s_b,
  output logic [31:0] ain,
  output logic [31:0] bin,
  input  logic [31:0] rp_result,
  input  logic        decouple,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [2:0]  inflight,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = RP_LATENCY + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OCC_W  = 16;

  logic [DATA_W-1:0] ain_q, ain_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic [2:0]        inflight_q, inflight_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic [OCC_W-1:0]  tag_pop;
  logic [OCC_W-1:0]  tag_pop_next;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  drop_sum;
  logic              accept;
  logic              push;
  logic              pop;

  // Number of set tag bits, i.e. results still travelling through the partition.
  function automatic logic [OCC_W-1:0] popcount(input logic [TAG_W-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < TAG_W; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Credit: every pair in flight reserves a FIFO slot.
  always_comb begin
    tag_pop = popcount(tag_q);
    occ     = tag_pop + OCC_W'(count_q);
  end

  assign s_ready = Reset_n && !decouple && (occ < OCC_W'(FIFO_DEPTH));

  // Next-state logic for operands, tag pipeline, FIFO pointers and counters.
  always_comb begin
    ain_d        = ain_q;
    bin_d        = bin_q;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_d       = drop_q;
    inflight_d   = inflight_q;
    m_valid_d    = m_valid_q;
    tag_pop_next = '0;
    drop_sum     = '0;

    accept = s_valid && s_ready;
    push   = tag_q[TAG_W-1] && !decouple;
    pop    = (count_q != '0) && m_ready;

    if (accept) begin
      ain_d = s_a;
      bin_d = s_b;
    end

    // Decouple isolates the partition immediately: every in-flight result
    // is abandoned and counted as dropped.
    if (decouple) begin
      tag_d    = '0;
      drop_sum = OCC_W'(drop_q) + tag_pop;
      drop_d   = (drop_sum > OCC_W'(255)) ? 8'hFF : 8'(drop_sum);
    end else begin
      tag_d = (tag_q << 1) | TAG_W'(accept);
    end

    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    m_valid_d = (count_d != '0);

    tag_pop_next = popcount(tag_d);
    inflight_d   = (tag_pop_next > OCC_W'(7)) ? 3'd7 : 3'(tag_pop_next);
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ain_q      <= '0;
      bin_q      <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      inflight_q <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      ain_q      <= ain_d;
      bin_q      <= bin_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
    end
  end

  // FIFO storage; contents need no reset since count/pointers gate visibility.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rp_result;
    end
  end

  assign ain      = ain_q;
  assign bin      = bin_q;
  assign m_valid  = m_valid_q;
  assign m_data   = mem_q[rd_ptr_q];
  assign inflight = inflight_q;
  assign drop_cnt = drop_q;

endmodule
